// File: rtl/pipe_add.sv
// pipe_add: pipelined carry-lookahead adder/subtractor with valid/ready backpressure
// Ports: clk, rst_n (async, active-low); in_valid/in_ready accept a, b, sub, cin;
// out_valid/out_ready present sum, cout (no-borrow on sub), ovf (signed), zero.
module pipe_add #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / 4;
  localparam int L  = STAGES - 1;

  // Slice adder: group carries are flat sum-of-products over group G/P,
  // bit carries are flat sum-of-products inside each 4-bit group.
  function automatic logic [SW:0] cla(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic ci);
    logic [SW-1:0] g, p, c;
    logic [NG-1:0] gg, gp;
    logic [NG:0] gc;
    logic t;
    g = x & y;
    p = x ^ y;
    for (int j = 0; j < NG; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int q = 0; q < 4; q++) begin
        gg[j] = g[4*j+q] | (p[4*j+q] & gg[j]);
        gp[j] = gp[j] & p[4*j+q];
      end
    end
    for (int j = 0; j <= NG; j++) begin
      gc[j] = ci;
      for (int i = 0; i < j; i++) gc[j] = gc[j] & gp[i];
      for (int i = 0; i < j; i++) begin
        t = gg[i];
        for (int m = i + 1; m < j; m++) t = t & gp[m];
        gc[j] = gc[j] | t;
      end
    end
    for (int j = 0; j < NG; j++)
      for (int q = 0; q < 4; q++) begin
        c[4*j+q] = gc[j];
        for (int i = 0; i < q; i++) c[4*j+q] = c[4*j+q] & p[4*j+i];
        for (int i = 0; i < q; i++) begin
          t = g[4*j+i];
          for (int m = i + 1; m < q; m++) t = t & p[4*j+m];
          c[4*j+q] = c[4*j+q] | t;
        end
      end
    return {gc[NG], p ^ c};
  endfunction

  logic             adv;
  logic [WIDTH-1:0] bp;
  logic [STAGES-1:0] v, c, xv, xc;
  logic [WIDTH-1:0] pa [STAGES];
  logic [WIDTH-1:0] pb [STAGES];
  logic [WIDTH-1:0] s  [STAGES];
  logic [WIDTH-1:0] xa [STAGES];
  logic [WIDTH-1:0] xb [STAGES];
  logic [WIDTH-1:0] xs [STAGES];
  logic [WIDTH-1:0] ns [STAGES];
  logic [SW:0]      r  [STAGES];

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign bp        = sub ? ~b : b;
  assign out_valid = v[L];
  assign cout      = c[L];
  assign sum       = s[L];

  // Stage k consumes what stage k-1 holds; stage 0 consumes the prepared inputs.
  // Full operands ride along so the sign bits reach the last stage for ovf.
  always_comb begin
    xv[0] = in_valid;
    xc[0] = sub | cin;
    xa[0] = a;
    xb[0] = bp;
    xs[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      xv[k] = v[k-1];
      xc[k] = c[k-1];
      xa[k] = pa[k-1];
      xb[k] = pb[k-1];
      xs[k] = s[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      r[k] = cla(xa[k][k*SW+:SW], xb[k][k*SW+:SW], xc[k]);
      ns[k] = xs[k];
      ns[k][k*SW+:SW] = r[k][SW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v    <= '0;
      c    <= '0;
      ovf  <= 1'b0;
      zero <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        pa[k] <= '0;
        pb[k] <= '0;
        s[k]  <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v[k]  <= xv[k];
        c[k]  <= r[k][SW];
        pa[k] <= xa[k];
        pb[k] <= xb[k];
        s[k]  <= ns[k];
      end
      ovf  <= (xa[L][WIDTH-1] == xb[L][WIDTH-1]) && (ns[L][WIDTH-1] != xa[L][WIDTH-1]);
      zero <= ~|ns[L];
    end
endmodule

// File: tb/tb_pipe_add.sv
// tb_pipe_add: directed and streamed checks of pipe_add including backpressure, reset and parameter sweep
module tb_pipe_add;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic iv = 1'b0, ordy = 1'b1, subv = 1'b0, cinv = 1'b0;
  logic [31:0] av = '0, bv = '0;
  logic ir, ov, oc, oo, oz;
  logic [31:0] os;
  logic [34:0] obs;
  assign obs = {oo, oz, oc, os};

  pipe_add #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(av), .b(bv), .sub(subv), .cin(cinv),
    .out_valid(ov), .out_ready(ordy), .sum(os), .cout(oc), .ovf(oo), .zero(oz));

  logic sv = 1'b0;
  logic [7:0]  a8 = '1;
  logic [15:0] a16 = '1;
  logic [63:0] a64 = '1;
  logic ir8, ov8, oc8, oo8, oz8, ir16, ov16, oc16, oo16, oz16, ir64, ov64, oc64, oo64, oz64;
  logic [7:0]  os8;
  logic [15:0] os16;
  logic [63:0] os64;

  pipe_add #(.WIDTH(8), .STAGES(1)) d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(ir8), .a(a8), .b(8'h0), .sub(1'b0), .cin(1'b1),
    .out_valid(ov8), .out_ready(1'b1), .sum(os8), .cout(oc8), .ovf(oo8), .zero(oz8));
  pipe_add #(.WIDTH(16), .STAGES(2)) d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(ir16), .a(a16), .b(16'h0), .sub(1'b0), .cin(1'b1),
    .out_valid(ov16), .out_ready(1'b1), .sum(os16), .cout(oc16), .ovf(oo16), .zero(oz16));
  pipe_add #(.WIDTH(64), .STAGES(8)) d64 (
    .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(ir64), .a(a64), .b(64'h0), .sub(1'b0), .cin(1'b1),
    .out_valid(ov64), .out_ready(1'b1), .sum(os64), .cout(oc64), .ovf(oo64), .zero(oz64));

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [34:0] rf(input logic [31:0] x, input logic [31:0] y, input logic s, input logic ci);
    logic [31:0] yb;
    logic [32:0] t;
    yb = s ? ~y : y;
    t = {1'b0, x} + {1'b0, yb} + {32'b0, s | ci};
    return {(x[31] == yb[31]) && (t[31] != x[31]), t[31:0] == 32'h0, t[32], t[31:0]};
  endfunction

  task automatic op(input string tag, input logic [31:0] x, input logic [31:0] y, input logic s,
                    input logic ci, input logic [34:0] exp);
    ordy = 1'b1; iv = 1'b1; av = x; bv = y; subv = s; cinv = ci;
    cyc;
    iv = 1'b0;
    repeat (2) cyc;
    chk({tag, "_early"}, ov, 1'b0);
    cyc;
    chk({tag, "_valid"}, ov, 1'b1);
    chk(tag, obs, exp);
    cyc;
  endtask

  task automatic stream(input string tag, input int n, input bit rnd);
    logic [34:0] q[$];
    logic [34:0] prev = '0;
    int sent = 0, got = 0, first = -1, last = -1;
    bit stall = 1'b0;
    for (int t = 0; t < 400 && got < n; t++) begin
      ordy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk({tag, "_in_ready"}, ir, !(ov && !ordy));
      if (stall && ov) chk({tag, "_hold"}, obs, prev);
      stall = ov && !ordy;
      prev = obs;
      if (ov && ordy) begin
        if (q.size() == 0) chk({tag, "_spurious"}, ov, 1'b0);
        else chk({tag, "_res"}, obs, q.pop_front());
        got++;
        if (first < 0) first = t;
        last = t;
      end
      iv = sent < n;
      if (iv) begin
        av = $urandom; bv = $urandom; subv = 1'($urandom_range(0, 1)); cinv = 1'($urandom_range(0, 1));
        if (sent == 5) begin av = 32'h0FFF_FFFF; bv = 32'h1; subv = 1'b0; cinv = 1'b0; end
        if (ir) begin q.push_back(rf(av, bv, subv, cinv)); sent++; end
      end
      cyc;
    end
    iv = 1'b0; ordy = 1'b1;
    chk({tag, "_count"}, got, n);
    if (!rnd) chk({tag, "_span"}, last - first + 1, n);
  endtask

  initial begin
    int l8 = 0, l16 = 0, l64 = 0, nv = 0;
    logic [9:0]  r8 = '0;
    logic [17:0] r16 = '0;
    logic [65:0] r64 = '0;
    repeat (2) cyc;
    chk("reset_out", {ov, obs}, 36'h0);
    chk("reset_in_ready", ir, 1'b1);
    #2 rst_n = 1'b1;
    cyc;
    op("allones_p1", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, {3'b011, 32'h0});
    op("pos_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {3'b100, 32'h8000_0000});
    op("sub_borrow", 32'h5, 32'h7, 1'b1, 1'b0, {3'b000, 32'hFFFF_FFFE});
    op("neg_ovf", 32'h8000_0000, 32'h1, 1'b1, 1'b0, {3'b101, 32'h7FFF_FFFF});
    op("slice_carry", 32'h0FFF_FFFF, 32'h1, 1'b0, 1'b0, {3'b000, 32'h1000_0000});
    op("cin_add", 32'h1, 32'h2, 1'b0, 1'b1, {3'b000, 32'h4});
    op("sub_nocin", 32'hA, 32'h3, 1'b1, 1'b0, {3'b001, 32'h7});
    stream("b2b", 16, 1'b0);
    stream("bp", 10, 1'b1);
    iv = 1'b1; ordy = 1'b1;
    for (int i = 0; i < 3; i++) begin av = i; bv = i; subv = 1'b0; cinv = 1'b0; cyc; end
    iv = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("midrst_valid", ov, 1'b0);
    chk("midrst_in_ready", ir, 1'b1);
    cyc;
    #2 rst_n = 1'b1;
    repeat (8) begin cyc; nv += int'(ov); end
    chk("stale", nv, 0);
    op("after_rst", 32'h3, 32'h4, 1'b0, 1'b0, {3'b000, 32'h7});
    iv = 1'b1; av = 32'h9; bv = 32'h1; subv = 1'b0; cinv = 1'b0; ordy = 1'b0;
    cyc;
    iv = 1'b0;
    repeat (4) cyc;
    chk("held_valid", {ov, obs}, {1'b1, 3'b000, 32'hA});
    chk("held_in_ready", ir, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {ov, obs}, 36'h0);
    chk("async_in_ready", ir, 1'b1);
    cyc;
    #2 rst_n = 1'b1;
    ordy = 1'b1;
    cyc;
    sv = 1'b1;
    cyc;
    sv = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      if (ov8 && l8 == 0) begin l8 = e; r8 = {oc8, oz8, os8}; end
      if (ov16 && l16 == 0) begin l16 = e; r16 = {oc16, oz16, os16}; end
      if (ov64 && l64 == 0) begin l64 = e; r64 = {oc64, oz64, os64}; end
      cyc;
    end
    chk("lat_8_1", l8, 1);
    chk("res_8_1", r8, {2'b11, 8'h0});
    chk("lat_16_2", l16, 2);
    chk("res_16_2", r16, {2'b11, 16'h0});
    chk("lat_64_8", l64, 8);
    chk("res_64_8", r64[63:0], 64'h0);
    chk("flags_64_8", r64[65:64], 2'b11);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
